counter_modulo_seq: RTL and testbench
=====================================

// Module: counter_modulo_seq
// PURPOSE
//  Sequencer for a modulo counter: counts 0..max under a tick enable and pulses on wrap.
//  Runs a programmed number of periods (or free-runs), then signals done.
//  New configuration arrives over a valid/ready handshake and takes effect glitch-free at a wrap.
//  Sits between a register/CSR front end and timing consumers (baud, frame, PWM).
// PARAMETERS
//  WIDTH    32   counter and max width
//  RPT_W    16   repeat-count width
//  MAX_RST  0    active max after reset
// PORTS
//  clk       in   1        clock
//  rst       in   1        reset, synchronous, active-high
//  cfg_vld   in   1        config valid
//  cfg_rdy   out  1        config ready
//  cfg_max   in   WIDTH    counter maximum (period = cfg_max+1 ticks)
//  cfg_rpt   in   RPT_W    periods to run; 0 = continuous
//  start     in   1        start sequence (IDLE only)
//  stop      in   1        abort sequence
//  ena       in   1        tick enable
//  cnt       out  WIDTH    counter value
//  pls       out  1        wrap pulse (combinational)
//  done      out  1        final-wrap pulse (combinational)
//  busy      out  1        state == RUN
//  irq       out  1        sticky done flag (only with macro)
//  irq_clr   in   1        clear irq (only with macro)
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, act_max=MAX_RST, act_rpt=0, shadow empty.
//    Outputs after reset: cfg_rdy=1, busy=0, pls=0, done=0, irq=0.
//  - Registers: active {max,rpt}, shadow {max,rpt}+pending flag, remaining-periods counter.
//  - cfg_rdy = ~pending. A transfer is cfg_vld & cfg_rdy.
//    In IDLE a transfer writes the active regs at the edge.
//    In RUN a transfer writes the shadow and sets pending.
//  - FSM IDLE: start & ~stop -> RUN. cnt=0. rem<=act_rpt. A start while in RUN is ignored.
//  - wrp = (cnt == act_max). max=0 gives wrp every ena cycle. Compare is full WIDTH, so max=2^WIDTH-1 is legal.
//  - RUN, ena & ~stop:
//    - wrp: cnt<=0 and pls=1 in the same cycle (0 latency).
//    - ~wrp: cnt<=cnt+1.
//    - ~ena: cnt holds and pls=0.
//  - Final wrap (act_rpt!=0 & rem==1):
//    - done=1 with pls.
//    - Next state IDLE. busy=0 the next cycle.
//  - Non-final wrap: rem decrements when act_rpt!=0.
//  - Non-final wrap with pending:
//    - Shadow -> active. pending clears. rem<=shadow rpt.
//    - New max applies from the next count.
//  - A transfer in the same cycle as a wrap (pending=0) goes to the shadow.
//    It is applied at the following wrap, not the current one.
//  - stop (any state): has priority over start, wrp and done. pls=0 and done=0 that cycle.
//    At the edge: cnt<=0, next state IDLE.
//  - On entry to IDLE (done or stop), a pending shadow moves to active and pending clears.
//  - Reset mid-operation: all state returns to the reset values at the next edge. No pls/done.
//  - Inputs other than rst are ignored during the reset cycle.
// CONFIGURATION
//  COUNTER_MODULO_SEQ_IRQ_EN
//  - Defined: ports irq/irq_clr exist. irq set by done, cleared by irq_clr.
//    Set wins when both occur in the same cycle. Reset value 0.
//  - Undefined: the irq and irq_clr ports are absent and no flag register is built.
// TESTING
//  1. WIDTH=4. cfg max=3 rpt=2, start, ena=1.
//     -> cnt 0,1,2,3,0,1,2,3. pls at both cnt=3. done with the 2nd pls only. busy=0 the next cycle. cnt=0.
//  2. max=0 rpt=0, ena toggling 1,0,1,0.
//     -> pls 1,0,1,0. cnt stays 0. done never. busy stays 1.
//  3. RUN max=4 rpt=0. At cnt=2 transfer max=1.
//     -> cfg_rdy=0 until the wrap. cnt 3,4,0,1,0,1. cfg_rdy=1 after the wrap.
//  4. stop asserted while cnt==max, ena=1.
//     -> pls=0, done=0. cnt=0 and IDLE the next cycle.
//     start+stop together in IDLE -> stays IDLE.
//  5. WIDTH=4, max=15, rpt=1.
//     -> cnt 0..15. pls and done at 15. Back to IDLE with cnt=0. No overflow glitch.
//  6. With the macro: done then irq_clr.
//     -> irq=1 from the cycle after done until the cycle after irq_clr. done with irq_clr in the same cycle leaves irq=1.

Source files
------------

// File: rtl/counter_modulo_seq.sv
// Modulo counter sequencer: counts 0..max on ena, pulses on wrap, runs N periods or free-runs.
// Optional sticky irq flag with irq/irq_clr ports when COUNTER_MODULO_SEQ_IRQ_EN is defined.
module counter_modulo_seq #(
    parameter int               WIDTH   = 32,
    parameter int               RPT_W   = 16,
    parameter logic [WIDTH-1:0] MAX_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic [RPT_W-1:0] cfg_rpt,
    input  logic             start,
    input  logic             stop,
    input  logic             ena,
    output logic [WIDTH-1:0] cnt,
    output logic             pls,
    output logic             done,
    output logic             busy
`ifdef COUNTER_MODULO_SEQ_IRQ_EN
    ,
    input  logic             irq_clr,
    output logic             irq
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] act_max;
    logic [RPT_W-1:0] act_rpt;
    logic [WIDTH-1:0] sh_max;
    logic [RPT_W-1:0] sh_rpt;
    logic             pending;
    logic [RPT_W-1:0] rem;

    logic xfer;
    logic wrp;
    logic run_tick;
    logic wrap_ev;
    logic final_ev;
    logic start_ev;
    logic to_idle;

    assign xfer     = cfg_vld & ~pending;
    assign wrp      = (cnt == act_max);
    // stop and rst suppress every counting event in their cycle
    assign run_tick = (state == RUN) & ena & ~stop & ~rst;
    assign wrap_ev  = run_tick & wrp;
    assign final_ev = wrap_ev & (act_rpt != '0) & (rem == RPT_W'(1));
    assign start_ev = (state == IDLE) & start & ~stop;
    assign to_idle  = (state == RUN) & (stop | final_ev);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ev) state_nxt = RUN;
            RUN:     if (stop | final_ev) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_rdy = ~pending;
        busy    = (state == RUN);
        pls     = wrap_ev;
        done    = final_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            act_max <= MAX_RST;
            act_rpt <= '0;
            sh_max  <= '0;
            sh_rpt  <= '0;
            pending <= 1'b0;
            rem     <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (xfer) begin
                act_max <= cfg_max;
                act_rpt <= cfg_rpt;
            end
            // A config accepted together with start governs the run it launches
            if (start_ev) begin
                rem <= xfer ? cfg_rpt : act_rpt;
            end
        end else if (to_idle) begin
            cnt <= '0;
            if (pending) begin
                act_max <= sh_max;
                act_rpt <= sh_rpt;
                pending <= 1'b0;
            end else if (xfer) begin
                act_max <= cfg_max;
                act_rpt <= cfg_rpt;
            end
        end else begin
            // pending and xfer are mutually exclusive, so shadow writes never race the swap
            if (xfer) begin
                sh_max  <= cfg_max;
                sh_rpt  <= cfg_rpt;
                pending <= 1'b1;
            end
            if (run_tick) begin
                if (wrp) begin
                    cnt <= '0;
                    if (pending) begin
                        act_max <= sh_max;
                        act_rpt <= sh_rpt;
                        pending <= 1'b0;
                        rem     <= sh_rpt;
                    end else if (act_rpt != '0) begin
                        rem <= rem - RPT_W'(1);
                    end
                end else begin
                    cnt <= cnt + WIDTH'(1);
                end
            end
        end
    end

`ifdef COUNTER_MODULO_SEQ_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (final_ev) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_counter_modulo_seq.sv
// Bench for counter_modulo_seq: directed scenarios then random traffic against a period-counting model.
module tb_counter_modulo_seq;

    localparam int WIDTH = 4;
    localparam int RPT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_vld;
    logic             cfg_rdy;
    logic [WIDTH-1:0] cfg_max;
    logic [RPT_W-1:0] cfg_rpt;
    logic             start;
    logic             stop;
    logic             ena;
    logic [WIDTH-1:0] cnt;
    logic             pls;
    logic             done;
    logic             busy;
    logic             irq_clr;
`ifdef COUNTER_MODULO_SEQ_IRQ_EN
    logic             irq;
`endif

    counter_modulo_seq #(
        .WIDTH  (WIDTH),
        .RPT_W  (RPT_W),
        .MAX_RST(4'd0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cfg_vld(cfg_vld),
        .cfg_rdy(cfg_rdy),
        .cfg_max(cfg_max),
        .cfg_rpt(cfg_rpt),
        .start  (start),
        .stop   (stop),
        .ena    (ena),
        .cnt    (cnt),
        .pls    (pls),
        .done   (done),
        .busy   (busy)
`ifdef COUNTER_MODULO_SEQ_IRQ_EN
        ,
        .irq_clr(irq_clr),
        .irq    (irq)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: periods completed so far, compared against the programmed repeat count
    bit m_valid = 0;
    bit m_run;
    int m_cnt, m_max, m_rpt, m_per;
    int q_max[$];
    int q_rpt[$];
    bit m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input bit r, input bit v, input bit st, input bit sp, input bit e,
                       input bit clr, input int mx, input int rp);
        bit e_pls, e_done, e_rdy, xf;
        rst = r; cfg_vld = v; start = st; stop = sp; ena = e; irq_clr = clr;
        cfg_max = WIDTH'(mx); cfg_rpt = RPT_W'(rp);
        @(negedge clk);
        e_rdy  = (q_max.size() == 0);
        e_pls  = !r && m_run && e && !sp && (m_cnt == m_max);
        e_done = e_pls && (m_rpt != 0) && (m_per + 1 == m_rpt);
        if (m_valid) begin
            check("cnt", 32'(cnt), 32'(m_cnt));
            check("pls", 32'(pls), 32'(e_pls));
            check("done", 32'(done), 32'(e_done));
            check("busy", 32'(busy), 32'(m_run));
            check("cfg_rdy", 32'(cfg_rdy), 32'(e_rdy));
`ifdef COUNTER_MODULO_SEQ_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
        end
        if (r) begin
            m_valid = 1; m_run = 0; m_cnt = 0; m_max = 0; m_rpt = 0; m_per = 0; m_irq = 0;
            q_max.delete(); q_rpt.delete();
        end else begin
            xf = v && e_rdy;
            if (e_done) m_irq = 1;
            else if (clr) m_irq = 0;
            if (!m_run) begin
                if (xf) begin m_max = mx; m_rpt = rp; end
                if (st && !sp) begin m_run = 1; m_per = 0; end
                m_cnt = 0;
            end else if (sp || e_done) begin
                m_run = 0; m_cnt = 0;
                if (q_max.size() != 0) begin
                    m_max = q_max.pop_front(); m_rpt = q_rpt.pop_front();
                end else if (xf) begin
                    m_max = mx; m_rpt = rp;
                end
            end else begin
                if (e_pls) begin
                    m_cnt = 0; m_per++;
                    if (q_max.size() != 0) begin
                        m_max = q_max.pop_front(); m_rpt = q_rpt.pop_front(); m_per = 0;
                    end
                end else if (e) begin
                    m_cnt++;
                end
                if (xf) begin q_max.push_back(mx); q_rpt.push_back(rp); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; cfg_vld = 0; start = 0; stop = 0; ena = 0; irq_clr = 0; cfg_max = 0; cfg_rpt = 0;
        @(posedge clk); #1;
        cyc(1, 1, 1, 0, 1, 0, 5, 5);
        @(negedge clk);
        check("rst_cnt", 32'(cnt), 0);
        check("rst_rdy", 32'(cfg_rdy), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_pls", 32'(pls), 0);
        check("rst_done", 32'(done), 0);
        @(posedge clk); #1;

        // max=3 rpt=2: two periods then done
        cyc(0, 1, 0, 0, 0, 0, 3, 2);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // max=0 free-run with toggling enable
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, (i % 2) == 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);

        // max=4 continuous, reconfigure to max=1 mid-period
        cyc(0, 1, 1, 0, 0, 0, 4, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 1, 0, 2, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);

        // stop exactly on the wrap, then start+stop in IDLE
        cyc(0, 1, 1, 0, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // full-range max=15, single period
        cyc(0, 1, 1, 0, 0, 0, 15, 1);
        for (int i = 0; i < 18; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // irq set by done, clear, and set winning over clear
        cyc(0, 1, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // reset mid-run
        cyc(0, 1, 1, 0, 0, 0, 2, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 200) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                ($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 10) == 0,
                (($urandom % 16) == 0) ? 15 : int'($urandom % 8), int'($urandom % 4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
